bubble_page_seq: RTL
====================

Name: bubble_page_seq

Overview:
- Sequences the bubble control front-end for one page access: starts shifting, tracks the absolute page position, and fires replicate (read) or swap (write) on the target page.
- Issues the page-counter start/stop, replicate-start, swap-start and valid-page strobes that the front-end latches into its shift, replicator and swap-gate enables.
- Sits between the host command interface and the front-end.

Parameters:
- PGW, 12, page address width.
- PAGES, 2053, pages per loop; position wraps PAGES-1 -> 0.
- ACC_ROT, 1, rotations the replicate/swap strobe is held per access (1..15).
- START_TMO, 2, rotation boundaries allowed for shift-enable to appear after start.

Ports:
- i_MCLK  in  1  master clock.
- i_SYS_RST  in  1  asynchronous, active-high reset.
- i_CLK2M_PCEN_n  in  1  2 MHz clock enable, active low. A cycle with this low is a "tick".
- i_ROT20_n  in  20  rotation phase, one-hot-low; bit 19 low marks the rotation boundary.
- i_BSEN_n  in  1  front-end shift-enable feedback; low means shifting.
- i_CMD_REQ  in  1  command request, level.
- i_CMD_WR  in  1  1 = write (swap), 0 = read (replicate).
- i_CMD_PAGE  in  PGW  target page.
- o_CMD_ACK  out  1  one-tick acknowledge.
- o_BUSY  out  1  high whenever the FSM is not in IDLE.
- o_CNT_START  out  1  page-counter start strobe to the front-end.
- o_CNT_STOP  out  1  page-counter stop strobe to the front-end.
- o_REP_START  out  1  replicate start.
- o_SWAP_START  out  1  swap start.
- o_VALPG_ACC_FLAG  out  1  valid page access.
- o_CUR_PAGE  out  PGW  current absolute page position.
- o_DONE  out  1  one-tick completion pulse.
- o_ERR  out  1  one-tick error pulse.

Behaviour:
- Clocking and reset:
  - Single clock i_MCLK. Asynchronous active-high reset i_SYS_RST.
  - All state changes on posedge i_MCLK, only on ticks. Outputs hold between ticks.
  - Reset: every output 0, FSM in IDLE, position counter 0, rotation counters 0. Reset mid-operation aborts immediately; strobes drop asynchronously.
- Position counter:
  - Increments on each tick where i_ROT20_n[19]=0 and i_BSEN_n=0.
  - Wraps PAGES-1 -> 0 (compare-and-clear, no modulo divider).
  - Drives o_CUR_PAGE directly.
- IDLE:
  - On a tick with i_CMD_REQ=1, latch WR and PAGE and pulse o_CMD_ACK for one tick.
  - If i_CMD_PAGE >= PAGES: also pulse o_ERR and remain in IDLE.
  - Otherwise go to START.
  - Requests are accepted only in IDLE; requests while busy receive no ack.
- START:
  - o_CNT_START=1.
  - On a tick that samples i_BSEN_n=0, go to SEEK.
  - If START_TMO rotation boundaries pass without that, pulse o_ERR and go to STOP.
- SEEK:
  - On a tick with i_ROT20_n[0]=0 and position == target, go to ACCESS.
  - Target == current position is legal (zero-distance seek).
- ACCESS:
  - o_VALPG_ACC_FLAG=1.
  - o_REP_START=~WR and o_SWAP_START=WR, held for ACC_ROT full rotations.
  - Rotations are counted at i_ROT20_n[19]=0. At the ACC_ROT-th boundary, go to STOP.
- STOP:
  - o_CNT_STOP=1 until a tick samples i_BSEN_n=1, then go to DONE.
- DONE: o_DONE=1 for one tick, then go to IDLE.
- Invariants:
  - o_CNT_START and o_CNT_STOP are never both 1.
  - o_REP_START and o_SWAP_START are never both 1.
  - o_VALPG_ACC_FLAG is 1 only in ACCESS.
- Latency: ack to first shift depends on front-end response. Access begins at most PAGES rotations after shift is established.

Decomposition:
- Package bubble_seq_pkg:
  - FSM state enum: IDLE, START, SEEK, ACCESS, STOP, DONE.
  - ROT_BOUNDARY=19 and ROT_ALIGN=0 phase indices.
  - Default PAGES and PGW.
- One natural sub-module: bubble_page_pos. It holds the wrap-around position counter with its tick/boundary/enable qualification, plus the equality compare against the latched target.

Test Plan:
1. Read page 5 from position 0: REQ=1, WR=0, PAGE=5, front-end model drops BSEN_n 2 ticks after CNT_START -> ACK once; REP_START high for exactly one rotation with CUR_PAGE=5; SWAP_START never high; CNT_STOP, then DONE; BUSY low after.
2. Write with wrap: position parked at 2051, PAGE=1, WR=1 -> CUR_PAGE steps 2052 -> 0 -> 1; SWAP_START and VALPG_ACC_FLAG high during the page-1 rotation only.
3. Out-of-range request: PAGE=2053 -> ACK and ERR on the same tick; BUSY stays 0; no strobes.
4. Start timeout: BSEN_n held high -> ERR after 2 boundaries; CNT_STOP asserted; DONE once BSEN_n=1.
5. Reset mid-ACCESS: i_SYS_RST pulse -> all outputs 0 asynchronously; CUR_PAGE=0; next REQ accepted normally.
6. Busy collision and CEN gating: second REQ during SEEK -> no ACK; hold i_CLK2M_PCEN_n high for 10 cycles -> no state or counter change.

Source files
------------

// File: rtl/bubble_page_seq_pkg.sv
// Shared types and constants for the bubble page-access sequencer.
// Rotation phase indices refer to bits of the one-hot-low 20-phase rotation bus.
package bubble_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEEK,
        ACCESS,
        STOP,
        DONE
    } seq_state_t;

    localparam int ROT_BOUNDARY = 19;
    localparam int ROT_ALIGN    = 0;

    localparam int DEF_PGW   = 12;
    localparam int DEF_PAGES = 2053;

endpackage

// File: rtl/bubble_page_seq_pos.sv
// Absolute page position of the bubble loop: steps once per rotation boundary
// while the front-end is shifting, wraps at PAGES, and flags a match with the target.
module bubble_page_pos
    import bubble_seq_pkg::*;
#(
    parameter int PGW   = DEF_PGW,
    parameter int PAGES = DEF_PAGES
) (
    input  logic           i_MCLK,
    input  logic           i_SYS_RST,
    input  logic           i_TICK,
    input  logic           i_ROT_BND_n,
    input  logic           i_BSEN_n,
    input  logic [PGW-1:0] i_TARGET,
    output logic [PGW-1:0] o_POS,
    output logic           o_MATCH
);

    logic [PGW-1:0] pos_reg;
    logic [PGW-1:0] pos_next;

    // Compare-and-clear keeps the wrap free of any divider.
    always_comb begin
        pos_next = pos_reg;
        if (i_TICK && !i_ROT_BND_n && !i_BSEN_n) begin
            if (pos_reg == PGW'(PAGES - 1))
                pos_next = '0;
            else
                pos_next = pos_reg + 1'b1;
        end
    end

    always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
        if (i_SYS_RST)
            pos_reg <= '0;
        else
            pos_reg <= pos_next;
    end

    assign o_POS   = pos_reg;
    assign o_MATCH = (pos_reg == i_TARGET);

endmodule

// File: rtl/bubble_page_seq.sv
// Page-access sequencer: starts the shift, seeks the target page, holds the
// replicate or swap strobe for ACC_ROT rotations, then stops the shift.
module bubble_page_seq
    import bubble_seq_pkg::*;
#(
    parameter int PGW       = DEF_PGW,
    parameter int PAGES     = DEF_PAGES,
    parameter int ACC_ROT   = 1,
    parameter int START_TMO = 2
) (
    input  logic           i_MCLK,
    input  logic           i_SYS_RST,
    input  logic           i_CLK2M_PCEN_n,
    input  logic [19:0]    i_ROT20_n,
    input  logic           i_BSEN_n,
    input  logic           i_CMD_REQ,
    input  logic           i_CMD_WR,
    input  logic [PGW-1:0] i_CMD_PAGE,
    output logic           o_CMD_ACK,
    output logic           o_BUSY,
    output logic           o_CNT_START,
    output logic           o_CNT_STOP,
    output logic           o_REP_START,
    output logic           o_SWAP_START,
    output logic           o_VALPG_ACC_FLAG,
    output logic [PGW-1:0] o_CUR_PAGE,
    output logic           o_DONE,
    output logic           o_ERR
);

    localparam int TMO_W = $clog2(START_TMO + 1);
    localparam logic [PGW:0] PAGES_X = PAGES[PGW:0];

    seq_state_t       state_reg, state_next;
    logic             wr_reg, wr_next;
    logic [PGW-1:0]   page_reg, page_next;
    logic [3:0]       rot_cnt_reg, rot_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             ack_reg, ack_next;
    logic             err_reg, err_next;

    logic tick;
    logic at_boundary;
    logic at_align;
    logic shifting;
    logic page_bad;
    logic page_match;
    logic unused_rot;

    assign tick        = ~i_CLK2M_PCEN_n;
    assign at_boundary = ~i_ROT20_n[ROT_BOUNDARY];
    assign at_align    = ~i_ROT20_n[ROT_ALIGN];
    assign shifting    = ~i_BSEN_n;
    assign page_bad    = ({1'b0, i_CMD_PAGE} >= PAGES_X);
    assign unused_rot  = ^i_ROT20_n[18:1];

    bubble_page_pos #(
        .PGW   (PGW),
        .PAGES (PAGES)
    ) u_pos (
        .i_MCLK      (i_MCLK),
        .i_SYS_RST   (i_SYS_RST),
        .i_TICK      (tick),
        .i_ROT_BND_n (i_ROT20_n[ROT_BOUNDARY]),
        .i_BSEN_n    (i_BSEN_n),
        .i_TARGET    (page_reg),
        .o_POS       (o_CUR_PAGE),
        .o_MATCH     (page_match)
    );

    always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
        if (i_SYS_RST) begin
            state_reg   <= IDLE;
            wr_reg      <= 1'b0;
            page_reg    <= '0;
            rot_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_reg      <= wr_next;
            page_reg    <= page_next;
            rot_cnt_reg <= rot_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
        end
    end

    // Everything advances only on ticks; ack/err pulses last exactly one tick.
    always_comb begin
        state_next   = state_reg;
        wr_next      = wr_reg;
        page_next    = page_reg;
        rot_cnt_next = rot_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        ack_next     = ack_reg;
        err_next     = err_reg;
        if (tick) begin
            ack_next = 1'b0;
            err_next = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_CMD_REQ) begin
                        ack_next  = 1'b1;
                        wr_next   = i_CMD_WR;
                        page_next = i_CMD_PAGE;
                        if (page_bad) begin
                            err_next = 1'b1;
                        end else begin
                            state_next   = START;
                            tmo_cnt_next = '0;
                        end
                    end
                end
                START: begin
                    if (shifting) begin
                        state_next = SEEK;
                    end else if (at_boundary) begin
                        if (tmo_cnt_reg == TMO_W'(START_TMO - 1)) begin
                            err_next   = 1'b1;
                            state_next = STOP;
                        end else begin
                            tmo_cnt_next = tmo_cnt_reg + 1'b1;
                        end
                    end
                end
                SEEK: begin
                    if (at_align && page_match) begin
                        state_next   = ACCESS;
                        rot_cnt_next = '0;
                    end
                end
                ACCESS: begin
                    if (at_boundary) begin
                        if (rot_cnt_reg == 4'(ACC_ROT - 1))
                            state_next = STOP;
                        else
                            rot_cnt_next = rot_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (!shifting)
                        state_next = DONE;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        o_BUSY           = (state_reg != IDLE);
        o_CNT_START      = 1'b0;
        o_CNT_STOP       = 1'b0;
        o_REP_START      = 1'b0;
        o_SWAP_START     = 1'b0;
        o_VALPG_ACC_FLAG = 1'b0;
        o_DONE           = 1'b0;
        case (state_reg)
            START:  o_CNT_START = 1'b1;
            ACCESS: begin
                o_VALPG_ACC_FLAG = 1'b1;
                o_REP_START      = ~wr_reg;
                o_SWAP_START     = wr_reg;
            end
            STOP:   o_CNT_STOP = 1'b1;
            DONE:   o_DONE = 1'b1;
            default: ;
        endcase
    end

    assign o_CMD_ACK = ack_reg;
    assign o_ERR     = err_reg;

endmodule
